// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//
// Contents:
//   F3_*            RV32I funct3 size/sign codes
//   lsu_state_t     sequencer states
//   lsu_access_err  decides on accept whether a request is illegal or misaligned
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Returns 1 when the request can't be performed: an unknown funct3, an
    // unsigned-size code on a store, or an address not aligned to the size.
    function automatic logic lsu_access_err(input logic       we,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addrLo);
        logic illegal;
        logic misaligned;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = we;
            default:          illegal = 1'b1;
        endcase
        // funct3[1:0] encodes the size for every legal code: 00 byte, 01 half, 10 word
        if (funct3[1:0] == 2'b01 && addrLo[0]) begin
            misaligned = 1'b1;
        end
        if (funct3[1:0] == 2'b10 && addrLo != 2'b00) begin
            misaligned = 1'b1;
        end
        return illegal | misaligned;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Load data extraction: selects the addressed byte or halfword of a memory
// word and sign- or zero-extends it to 32 bits.
//
// Ports:
//   word_i      raw 32-bit memory word
//   byte_off_i  byte address bits [1:0] (bit 1 picks the halfword)
//   funct3_i    RV32I load size/sign code
//   data_o      extended load value (0 for codes that are not loads)
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = 8'h00;
        case (byte_off_i)
            2'd0:    byteSel = word_i[7:0];
            2'd1:    byteSel = word_i[15:8];
            2'd2:    byteSel = word_i[23:16];
            default: byteSel = word_i[31:24];
        endcase

        halfSel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];

        data_o = 32'h0;
        case (funct3_i)
            F3_B:    data_o = {{24{byteSel[7]}}, byteSel};
            F3_BU:   data_o = {24'h0, byteSel};
            F3_H:    data_o = {{16{halfSel[15]}}, halfSel};
            F3_HU:   data_o = {16'h0, halfSel};
            F3_W:    data_o = word_i;
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a word-only data memory
// (single write enable, combinational read, word-wide write).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake; ready only while IDLE
//   req_we, req_funct3          store/load flag and RV32I size/sign code
//   req_addr, req_wdata         byte address and right-justified store data
//   resp_valid                  one-cycle completion pulse
//   resp_rdata, resp_err        extended load data / error flag, valid with resp_valid
//   mem_we, mem_a, mem_wd       memory write enable, word address, write data
//   mem_rd                      memory read data, combinational from mem_a
//
// Loads:    IDLE -> READ -> RESP
// SW:       IDLE -> WRITE -> RESP
// SB/SH:    IDLE -> READ -> WRITE -> RESP (read-modify-write)
// Errors:   IDLE -> RESP, no memory access
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [2:0]                req_funct3,
    input  logic [31:0]               req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      resp_err,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]     mem_wd,
    input  logic [DATA_WIDTH-1:0]     mem_rd
);

    // Byte-address bits that actually reach the memory; higher bits wrap away.
    localparam int AW = MEM_ADDR_WIDTH + 2;

    lsu_state_t            state_q;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] oldWord_q;
    logic                  respValid_q;
    logic [DATA_WIDTH-1:0] respRdata_q;
    logic                  respErr_q;

    logic                  accept;
    logic [DATA_WIDTH-1:0] loadData;
    logic [DATA_WIDTH-1:0] mergedWord;
    logic                  unusedAddrBits;

    assign unusedAddrBits = ^req_addr[31:AW];

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // Memory-side outputs are decoded from state alone, so an asynchronous
    // reset removes a pending write in the same cycle it is asserted.
    assign mem_we = (state_q == WRITE);
    assign mem_a  = (state_q == READ || state_q == WRITE) ? addr_q[AW-1:2] : '0;
    assign mem_wd = (state_q == WRITE) ? mergedWord : '0;

    assign resp_valid = respValid_q;
    assign resp_rdata = respRdata_q;
    assign resp_err   = respErr_q;

    // Extraction reads mem_rd directly so the load value can be registered
    // straight into the response at the end of READ.
    lsu_load_extract u_extract (
        .word_i     (mem_rd),
        .byte_off_i (addr_q[1:0]),
        .funct3_i   (funct3_q),
        .data_o     (loadData)
    );

    // Store merge: sub-word stores overwrite only the addressed lane of the
    // word captured during READ; SW bypasses the old word entirely.
    always_comb begin
        mergedWord = wdata_q;
        if (funct3_q == F3_B) begin
            mergedWord = oldWord_q;
            case (addr_q[1:0])
                2'd0:    mergedWord[7:0]   = wdata_q[7:0];
                2'd1:    mergedWord[15:8]  = wdata_q[7:0];
                2'd2:    mergedWord[23:16] = wdata_q[7:0];
                default: mergedWord[31:24] = wdata_q[7:0];
            endcase
        end else if (funct3_q == F3_H) begin
            mergedWord = oldWord_q;
            if (addr_q[1]) begin
                mergedWord[31:16] = wdata_q[15:0];
            end else begin
                mergedWord[15:0]  = wdata_q[15:0];
            end
        end
    end

    // Sequencer: the request is latched on accept so later req_* changes are
    // ignored; response registers are loaded on entry to RESP and cleared
    // on leaving it, which makes resp_valid a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            oldWord_q   <= '0;
            respValid_q <= 1'b0;
            respRdata_q <= '0;
            respErr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr[AW-1:0];
                        wdata_q  <= req_wdata;
                        if (lsu_access_err(req_we, req_funct3, req_addr[1:0])) begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                            respErr_q   <= 1'b1;
                            respRdata_q <= '0;
                        end else if (req_we && req_funct3 == F3_W) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    oldWord_q <= mem_rd;
                    if (we_q) begin
                        state_q <= WRITE;
                    end else begin
                        state_q     <= RESP;
                        respValid_q <= 1'b1;
                        respRdata_q <= loadData;
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    respValid_q <= 1'b1;
                    respRdata_q <= '0;
                end
                RESP: begin
                    state_q     <= IDLE;
                    respValid_q <= 1'b0;
                    respRdata_q <= '0;
                    respErr_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [15:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MEM_ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, synchronous write.
    assign mem_rd = mem[mem_a];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_wd;
    end

    // One comparison; counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issues one request, scrambles the req_* inputs right after accept, then
    // watches each following cycle until resp_valid (bounded) and checks
    // latency, response data/error, and when/where the memory write happened.
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int expLat, input logic [31:0] expRdata, input logic expErr,
                                 input int expWeCycle, input logic [15:0] expMemA, input logic [31:0] expMemWd);
        int lat;
        int weCount;
        int weCycle;
        logic [15:0] seenA;
        logic [31:0] seenWd;
        bit done;
        lat = 0; weCount = 0; weCycle = 0; seenA = '0; seenWd = '0; done = 0;
        @(negedge clk);
        checkOutput($sformatf("%s.ready", tag), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = ~addr; req_wdata = ~wdata;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (mem_we) begin
                weCount++;
                if (weCycle == 0) begin
                    weCycle = lat; seenA = mem_a; seenWd = mem_wd;
                end
            end
            if (resp_valid) done = 1;
        end
        checkOutput($sformatf("%s.latency", tag), lat, expLat);
        checkOutput($sformatf("%s.rdata", tag), resp_rdata, expRdata);
        checkOutput($sformatf("%s.err", tag), {31'b0, resp_err}, {31'b0, expErr});
        checkOutput($sformatf("%s.we_cycle", tag), weCycle, expWeCycle);
        checkOutput($sformatf("%s.we_count", tag), weCount, (expWeCycle != 0) ? 32'd1 : 32'd0);
        if (expWeCycle != 0) begin
            checkOutput($sformatf("%s.mem_a", tag), {16'b0, seenA}, {16'b0, expMemA});
            checkOutput($sformatf("%s.mem_wd", tag), seenWd, expMemWd);
        end
        @(negedge clk);
        checkOutput($sformatf("%s.pulse_end", tag), {31'b0, resp_valid}, 32'd0);
        checkOutput($sformatf("%s.ready_after", tag), {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int respSeen;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[3] = 32'h8899AABB;
        mem[5] = 32'hCAFEF00D;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state
        @(negedge clk);
        checkOutput("reset.resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("reset.resp_rdata", resp_rdata, 32'd0);
        checkOutput("reset.resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("reset.mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("reset.req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset.mem_a", {16'b0, mem_a}, 32'd0);
        checkOutput("reset.mem_wd", mem_wd, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Loads from word 3 = 0x8899AABB
        applyStimulus("lb_0f",  1'b0, 3'b000, 32'h0000000F, 32'h0, 2, 32'hFFFFFF88, 1'b0, 0, 16'h0, 32'h0);
        applyStimulus("lbu_0f", 1'b0, 3'b100, 32'h0000000F, 32'h0, 2, 32'h00000088, 1'b0, 0, 16'h0, 32'h0);
        applyStimulus("lhu_0c", 1'b0, 3'b101, 32'h0000000C, 32'h0, 2, 32'h0000AABB, 1'b0, 0, 16'h0, 32'h0);
        applyStimulus("lh_0e",  1'b0, 3'b001, 32'h0000000E, 32'h0, 2, 32'hFFFF8899, 1'b0, 0, 16'h0, 32'h0);

        // Sub-word stores as read-modify-write
        applyStimulus("sb_0d",  1'b1, 3'b000, 32'h0000000D, 32'h123456CC, 3, 32'h0, 1'b0, 2, 16'h0003, 32'h8899CCBB);
        applyStimulus("lw_0c",  1'b0, 3'b010, 32'h0000000C, 32'h0, 2, 32'h8899CCBB, 1'b0, 0, 16'h0, 32'h0);
        applyStimulus("sh_0e",  1'b1, 3'b001, 32'h0000000E, 32'h55551234, 3, 32'h0, 1'b0, 2, 16'h0003, 32'h1234CCBB);
        applyStimulus("lhu_0e", 1'b0, 3'b101, 32'h0000000E, 32'h0, 2, 32'h00001234, 1'b0, 0, 16'h0, 32'h0);
        applyStimulus("lb_0c",  1'b0, 3'b000, 32'h0000000C, 32'h0, 2, 32'hFFFFFFBB, 1'b0, 0, 16'h0, 32'h0);
        applyStimulus("lbu_0d", 1'b0, 3'b100, 32'h0000000D, 32'h0, 2, 32'h000000CC, 1'b0, 0, 16'h0, 32'h0);

        // Full-word store skips READ; upper address bits wrap
        applyStimulus("sw_10",  1'b1, 3'b010, 32'h00000010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 16'h0004, 32'hDEADBEEF);
        applyStimulus("lw_10",  1'b0, 3'b010, 32'h00000010, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 16'h0, 32'h0);
        applyStimulus("lw_wrap", 1'b0, 3'b010, 32'h00040010, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 16'h0, 32'h0);

        // Error cases
        applyStimulus("err_lw_02",   1'b0, 3'b010, 32'h00000002, 32'h0, 1, 32'h0, 1'b1, 0, 16'h0, 32'h0);
        applyStimulus("err_sh_01",   1'b1, 3'b001, 32'h00000001, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 0, 16'h0, 32'h0);
        applyStimulus("err_st_f100", 1'b1, 3'b100, 32'h00000010, 32'h11111111, 1, 32'h0, 1'b1, 0, 16'h0, 32'h0);
        applyStimulus("err_ld_f011", 1'b0, 3'b011, 32'h00000010, 32'h0, 1, 32'h0, 1'b1, 0, 16'h0, 32'h0);

        // Reset asserted during the WRITE of an SH drops the write and response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h00000014; req_wdata = 32'h0000FFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("midsh.we_in_read", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        checkOutput("midsh.we_in_write", {31'b0, mem_we}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midsh.we_dropped", {31'b0, mem_we}, 32'd0);
        checkOutput("midsh.ready", {31'b0, req_ready}, 32'd1);
        checkOutput("midsh.resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        respSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) respSeen++;
        end
        checkOutput("midsh.no_resp", respSeen, 32'd0);
        applyStimulus("midsh.lw_14", 1'b0, 3'b010, 32'h00000014, 32'h0, 2, 32'hCAFEF00D, 1'b0, 0, 16'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
